// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports, a writeback port and a load-return port,
// plus a per-register pending-load scoreboard. Define REGFILE_BYPASS_EN to forward same-cycle writes.
module regfile_mp #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2,
   localparam int AW   = $clog2(NREGS),
   localparam int CW   = $clog2(NREGS + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NRD*AW-1:0]   rs_num,
   output logic [NRD*XLEN-1:0] rs_data,
   output logic [NRD-1:0]      rs_busy,
   input  logic                wa_en,
   input  logic [AW-1:0]       wa_num,
   input  logic [XLEN-1:0]     wa_data,
   input  logic                li_en,
   input  logic [AW-1:0]       li_num,
   input  logic                wl_en,
   input  logic [AW-1:0]       wl_num,
   input  logic [XLEN-1:0]     wl_data,
   output logic [CW-1:0]       busy_cnt,
   output logic                err
);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  regs_d [NREGS];
   logic [NREGS-1:0] busy_q, busy_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q, err_d;

   // One-hot decodes of the three write/issue ports; bit 0 is forced low so x0 is never touched.
   logic [NREGS-1:0] wa_hit, li_set, wl_clr;
   logic [AW-1:0]    rd_idx;

   // NOTE: every variable written in an always_comb gets a default first so no latch is inferred.
   always_comb begin
      wa_hit = '0;
      li_set = '0;
      wl_clr = '0;
      if (wa_en) wa_hit[wa_num] = 1'b1;
      if (li_en) li_set[li_num] = 1'b1;
      if (wl_en) wl_clr[wl_num] = 1'b1;
      wa_hit[0] = 1'b0;
      li_set[0] = 1'b0;
      wl_clr[0] = 1'b0;
   end

   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      err_d  = err_q;
      cnt_d  = '0;
      for (int r = 1; r < NREGS; r++) begin
         // Writeback is the younger result, so it overrides a same-cycle load return.
         if (wl_clr[r]) regs_d[r] = wl_data;
         if (wa_hit[r]) regs_d[r] = wa_data;
         if (li_set[r])      busy_d[r] = 1'b1;
         else if (wl_clr[r]) busy_d[r] = 1'b0;
         if ((wa_hit[r] && (wl_clr[r] || busy_q[r])) ||
             (li_set[r] && !wl_clr[r] && busy_q[r]) ||
             (wl_clr[r] && !li_set[r] && !busy_q[r]))
            err_d = 1'b1;
      end
      for (int r = 0; r < NREGS; r++) cnt_d = cnt_d + CW'(busy_d[r]);
   end

   always_comb begin
      rs_data = '0;
      rs_busy = '0;
      rd_idx  = '0;
      for (int k = 0; k < NRD; k++) begin
         rd_idx = rs_num[k*AW +: AW];
         if (rd_idx != '0) begin
            rs_data[k*XLEN +: XLEN] = regs_q[rd_idx];
            rs_busy[k]              = busy_q[rd_idx];
`ifdef REGFILE_BYPASS_EN
            // Writes are ignored during reset, so there is nothing to forward then.
            if (reset && wl_clr[rd_idx]) begin
               rs_data[k*XLEN +: XLEN] = wl_data;
               rs_busy[k]              = 1'b0;
            end
            if (reset && wa_hit[rd_idx]) rs_data[k*XLEN +: XLEN] = wa_data;
`endif
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   // NOTE: the array is reset because reads must return zero from reset onward.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
         busy_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign busy_cnt = cnt_q;
   assign err      = err_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against an array-based reference model.
module tb_regfile_mp;
   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 3;
   localparam int AW    = 5;
   localparam int CW    = 6;

   logic                clk;
   logic                reset;
   logic [NRD*AW-1:0]   rs_num;
   logic [NRD*XLEN-1:0] rs_data;
   logic [NRD-1:0]      rs_busy;
   logic                wa_en, li_en, wl_en;
   logic [AW-1:0]       wa_num, li_num, wl_num;
   logic [XLEN-1:0]     wa_data, wl_data;
   logic [CW-1:0]       busy_cnt;
   logic                err;

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
      .clk(clk), .reset(reset), .rs_num(rs_num), .rs_data(rs_data), .rs_busy(rs_busy),
      .wa_en(wa_en), .wa_num(wa_num), .wa_data(wa_data),
      .li_en(li_en), .li_num(li_num),
      .wl_en(wl_en), .wl_num(wl_num), .wl_data(wl_data),
      .busy_cnt(busy_cnt), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: architectural contents, pending flags and the sticky error.
   logic [XLEN-1:0] m_reg  [NREGS];
   bit              m_busy [NREGS];
   bit              m_err;

   task automatic model_clear();
      for (int i = 0; i < NREGS; i++) begin
         m_reg[i]  = '0;
         m_busy[i] = 1'b0;
      end
      m_err = 1'b0;
   endtask

   task automatic model_edge();
      bit wa, li, wl;
      if (!reset) return;
      wa = wa_en && wa_num != 0;
      li = li_en && li_num != 0;
      wl = wl_en && wl_num != 0;
      if (wa && wl && wa_num == wl_num) m_err = 1'b1;
      if (wa && m_busy[wa_num] && !(wl && wl_num == wa_num)) m_err = 1'b1;
      if (li && m_busy[li_num] && !(wl && wl_num == li_num)) m_err = 1'b1;
      if (wl && !m_busy[wl_num] && !(li && li_num == wl_num)) m_err = 1'b1;
      if (wl) m_reg[wl_num] = wl_data;
      if (wa) m_reg[wa_num] = wa_data;
      if (wl) m_busy[wl_num] = 1'b0;
      if (li) m_busy[li_num] = 1'b1;
   endtask

   // Compare process: mid-cycle, after inputs have settled, against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         int              cnt;
         logic [AW-1:0]   idx;
         logic [XLEN-1:0] ed;
         logic            eb;
         for (int k = 0; k < NRD; k++) begin
            idx = rs_num[k*AW +: AW];
            ed  = '0;
            eb  = 1'b0;
            if (idx != 0) begin
               ed = m_reg[idx];
               eb = m_busy[idx];
`ifdef REGFILE_BYPASS_EN
               if (reset) begin
                  if (wl_en && wl_num == idx) begin
                     ed = wl_data;
                     eb = 1'b0;
                  end
                  if (wa_en && wa_num == idx) ed = wa_data;
               end
`endif
            end
            check($sformatf("rs_data[%0d]", k), rs_data[k*XLEN +: XLEN], ed);
            check($sformatf("rs_busy[%0d]", k), rs_busy[k], eb);
         end
         cnt = 0;
         for (int i = 0; i < NREGS; i++) cnt += int'(m_busy[i]);
         check("busy_cnt", busy_cnt, cnt);
         check("err", err, m_err);
      end
   end

   function automatic logic [XLEN-1:0] rd(input int k);
      return rs_data[k*XLEN +: XLEN];
   endfunction

   function automatic logic [AW-1:0] pick();
      if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREGS - 1));
      return AW'($urandom_range(0, 7));
   endfunction

   task automatic idle();
      wa_en = 1'b0; wa_num = '0; wa_data = '0;
      li_en = 1'b0; li_num = '0;
      wl_en = 1'b0; wl_num = '0; wl_data = '0;
   endtask

   task automatic set_rs(input int a, input int b, input int c);
      rs_num = {AW'(c), AW'(b), AW'(a)};
   endtask

   task automatic set_in(input bit wae, input int wan, input logic [XLEN-1:0] wad,
                         input bit lie, input int lin,
                         input bit wle, input int wln, input logic [XLEN-1:0] wld);
      wa_en = wae; wa_num = AW'(wan); wa_data = wad;
      li_en = lie; li_num = AW'(lin);
      wl_en = wle; wl_num = AW'(wln); wl_data = wld;
   endtask

   task automatic rand_in();
      wa_en = ($urandom_range(0, 2) == 0); wa_num = pick(); wa_data = $urandom;
      li_en = ($urandom_range(0, 2) == 0); li_num = pick();
      wl_en = ($urandom_range(0, 2) == 0); wl_num = pick(); wl_data = $urandom;
      rs_num = {pick(), pick(), pick()};
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #2;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #3;
      reset = 1'b0;
      model_clear();
      @(posedge clk);
      #2;
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      idle();
      set_rs(0, 0, 0);
      model_clear();
      cmp_en = 1'b1;

      // Reset held with random inputs, then released.
      repeat (5) begin
         rand_in();
         tick();
      end
      idle();
      set_rs(1, 2, 31);
      reset = 1'b1;
      #1;
      for (int k = 0; k < NRD; k++) check("reset rs_data", rd(k), 32'h0);
      check("reset rs_busy", rs_busy, 3'b000);
      check("reset busy_cnt", busy_cnt, 0);
      check("reset err", err, 1'b0);

      // Basic write/read and x0 hardwiring.
      set_in(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      tick();
      idle();
      set_rs(5, 5, 5);
      #1;
      for (int k = 0; k < NRD; k++) check("x5 read", rd(k), 32'hDEADBEEF);
      set_in(1, 0, 32'h1234, 0, 0, 0, 0, 0);
      tick();
      idle();
      set_rs(0, 0, 0);
      #1;
      check("x0 read", rd(0), 32'h0);

      // Load issue and return on x7.
      set_in(0, 0, 0, 1, 7, 0, 0, 0);
      tick();
      idle();
      set_rs(7, 7, 7);
      #1;
      check("x7 pending busy", rs_busy, 3'b111);
      check("x7 pending cnt", busy_cnt, 1);
      tick();
      set_in(0, 0, 0, 0, 0, 1, 7, 32'h55);
      tick();
      idle();
      #1;
      check("x7 returned busy", rs_busy, 3'b000);
      check("x7 returned cnt", busy_cnt, 0);
      check("x7 data", rd(0), 32'h55);
      check("x7 err", err, 1'b0);

      // Asynchronous reset in the middle of three outstanding loads.
      for (int r = 1; r <= 3; r++) begin
         set_in(0, 0, 0, 1, r, 0, 0, 0);
         tick();
      end
      idle();
      #1;
      check("three pending cnt", busy_cnt, 3);
      @(negedge clk);
      #3;
      reset = 1'b0;
      model_clear();
      #1;
      check("async reset cnt", busy_cnt, 0);
      @(posedge clk);
      #2;
      reset = 1'b1;

      // Issue and return on x4 in the same cycle keeps it pending.
      set_in(0, 0, 0, 1, 4, 0, 0, 0);
      tick();
      set_in(0, 0, 0, 1, 4, 1, 4, 32'hC);
      tick();
      idle();
      set_rs(4, 4, 4);
      #1;
      check("x4 data", rd(0), 32'hC);
      check("x4 busy", rs_busy[0], 1'b1);
      check("x4 err", err, 1'b0);
      check("x4 cnt", busy_cnt, 1);

      // Writeback and load return collide on pending x9.
      set_in(0, 0, 0, 1, 9, 0, 0, 0);
      tick();
      set_in(1, 9, 32'hA, 0, 0, 1, 9, 32'hB);
      tick();
      idle();
      set_rs(9, 9, 9);
      #1;
      check("x9 data", rd(0), 32'hA);
      check("x9 busy", rs_busy[0], 1'b0);
      check("x9 err", err, 1'b1);

      // Unexpected return on x3: sticky error until reset.
      pulse_reset();
      set_in(0, 0, 0, 0, 0, 1, 3, 32'h33);
      tick();
      idle();
      set_rs(3, 3, 3);
      #1;
      check("x3 err", err, 1'b1);
      check("x3 data", rd(0), 32'h33);
      repeat (3) tick();
      check("x3 err sticky", err, 1'b1);
      pulse_reset();
      #1;
      check("err cleared", err, 1'b0);

      // Double issue on x6.
      set_in(0, 0, 0, 1, 6, 0, 0, 0);
      tick();
      set_in(0, 0, 0, 1, 6, 0, 0, 0);
      tick();
      idle();
      #1;
      check("x6 err", err, 1'b1);
      check("x6 cnt", busy_cnt, 1);

      // Read of x8 while its load returns.
      pulse_reset();
      set_in(1, 8, 32'h11, 0, 0, 0, 0, 0);
      tick();
      set_in(0, 0, 0, 1, 8, 0, 0, 0);
      tick();
      set_in(0, 0, 0, 0, 0, 1, 8, 32'h77);
      set_rs(8, 8, 8);
      #1;
`ifdef REGFILE_BYPASS_EN
      check("x8 forwarded data", rd(0), 32'h77);
      check("x8 forwarded busy", rs_busy[0], 1'b0);
`else
      check("x8 old data", rd(0), 32'h11);
      check("x8 old busy", rs_busy[0], 1'b1);
`endif
      tick();
      idle();

      // Randomized traffic with occasional resets.
      pulse_reset();
      repeat (3000) begin
         rand_in();
         tick();
         if ($urandom_range(0, 199) == 0) pulse_reset();
      end
      idle();
      tick();
      cmp_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
